// File: rtl/div_ctrl.sv
// Multi-cycle 32-bit restoring divider (DIV/DIVU) with pipeline stall handshake.
// Result packs remainder in [63:32] (HI) and quotient in [31:0] (LO).
module div_ctrl (
   input  logic        clk,
   input  logic        rst,
   input  logic        start_i,
   input  logic        signed_i,
   input  logic [31:0] opa_i,
   input  logic [31:0] opb_i,
   input  logic        cancel_i,
   output logic        stall_o,
   output logic        ready_o,
   output logic [63:0] result_o
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t      r_state;
   logic [4:0]  r_cnt;
   logic [31:0] r_rem;
   logic [31:0] r_quo;
   logic [31:0] r_dvsr;
   logic [31:0] r_opa;
   logic        r_sa;
   logic        r_sb;
   logic        r_signed;
   logic [63:0] r_result;

   logic [32:0] w_shift;
   logic [32:0] w_diff;
   logic        w_ge;
   logic [31:0] w_rem_nxt;
   logic [31:0] w_quo_nxt;
   logic        w_accept;

   function automatic logic [31:0] f_abs(input logic [31:0] v, input logic neg);
      return neg ? (~v + 32'd1) : v;
   endfunction

   // Divide-by-zero bypasses sign correction and returns the raw dividend in HI.
   function automatic logic [63:0] f_fix(input logic [31:0] rem,
                                         input logic [31:0] quo,
                                         input logic        sa,
                                         input logic        sb,
                                         input logic        sgn,
                                         input logic        dvsr_zero,
                                         input logic [31:0] opa);
      logic [31:0] q;
      logic [31:0] r;
      if (dvsr_zero)
         return {opa, 32'hFFFF_FFFF};
      q = (sgn && (sa ^ sb)) ? (~quo + 32'd1) : quo;
      r = (sgn && sa) ? (~rem + 32'd1) : rem;
      return {r, q};
   endfunction

   // One restoring step; bit 32 of the difference is the borrow, so the
   // shifted-out remainder bit takes part in the compare.
   assign w_shift   = {r_rem, r_quo[31]};
   assign w_diff    = w_shift - {1'b0, r_dvsr};
   assign w_ge      = ~w_diff[32];
   assign w_rem_nxt = w_ge ? w_diff[31:0] : w_shift[31:0];
   assign w_quo_nxt = {r_quo[30:0], w_ge};

   assign w_accept = (r_state == S_IDLE) && start_i && !cancel_i;

   assign stall_o  = !rst && !cancel_i &&
                     (((r_state == S_IDLE) && start_i) || (r_state == S_RUN));
   assign ready_o  = !rst && !cancel_i && (r_state == S_DONE);
   assign result_o = r_result;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= S_IDLE;
         r_cnt    <= 5'd0;
         r_rem    <= 32'd0;
         r_quo    <= 32'd0;
         r_dvsr   <= 32'd0;
         r_opa    <= 32'd0;
         r_sa     <= 1'b0;
         r_sb     <= 1'b0;
         r_signed <= 1'b0;
         r_result <= 64'd0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_sa     <= opa_i[31];
                  r_sb     <= opb_i[31];
                  r_signed <= signed_i;
                  r_quo    <= f_abs(opa_i, signed_i & opa_i[31]);
                  r_dvsr   <= f_abs(opb_i, signed_i & opb_i[31]);
                  r_opa    <= opa_i;
                  r_rem    <= 32'd0;
                  r_cnt    <= 5'd0;
                  r_state  <= S_RUN;
               end
            end
            S_RUN: begin
               if (cancel_i) begin
                  r_state <= S_IDLE;
               end else begin
                  r_rem <= w_rem_nxt;
                  r_quo <= w_quo_nxt;
                  r_cnt <= r_cnt + 5'd1;
                  if (r_cnt == 5'd31) begin
                     r_state  <= S_DONE;
                     r_result <= f_fix(w_rem_nxt, w_quo_nxt, r_sa, r_sb, r_signed,
                                       (r_dvsr == 32'd0), r_opa);
                  end
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_div_ctrl.sv
// Directed bench for div_ctrl: latency, signed/unsigned results, divide-by-zero,
// cancel in RUN and DONE, reset mid-operation and start held through DONE.
module tb_div_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        start_i;
   logic        signed_i;
   logic [31:0] opa_i;
   logic [31:0] opb_i;
   logic        cancel_i;
   logic        stall_o;
   logic        ready_o;
   logic [63:0] result_o;

   int n_chk  = 0;
   int n_fail = 0;
   logic [63:0] last_exp = 64'd0;

   always #5 clk = ~clk;

   div_ctrl dut (
      .clk      (clk),
      .rst      (rst),
      .start_i  (start_i),
      .signed_i (signed_i),
      .opa_i    (opa_i),
      .opb_i    (opb_i),
      .cancel_i (cancel_i),
      .stall_o  (stall_o),
      .ready_o  (ready_o),
      .result_o (result_o)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Issues one divide at cycle 0 and observes cycles 0..37; operands are
   // scrambled after the accept cycle. With hold=1 start stays high through DONE.
   task automatic do_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                         input logic hold, output int stall_bad, output int ready_at,
                         output int pulses, output logic [63:0] res,
                         output logic stall_after);
      stall_bad   = 0;
      ready_at    = -1;
      pulses      = 0;
      res         = 64'd0;
      stall_after = 1'b1;
      start_i  = 1'b1;
      signed_i = sgn;
      opa_i    = a;
      opb_i    = b;
      cancel_i = 1'b0;
      for (int k = 0; k < 38; k++) begin
         @(negedge clk);
         if (k <= 32 && stall_o !== 1'b1) stall_bad++;
         if (k == 33 && stall_o !== 1'b0) stall_bad++;
         if (ready_o === 1'b1) begin
            pulses++;
            if (ready_at < 0) begin
               ready_at = k;
               res      = result_o;
            end
         end
         if (k == 34) stall_after = stall_o;
         tick();
         opa_i    = $urandom;
         opb_i    = $urandom;
         signed_i = 1'($urandom_range(0, 1));
         if (!hold || k >= 33) start_i = 1'b0;
      end
   endtask

   task automatic test_reset;
      rst = 1'b1; start_i = 1'b1; cancel_i = 1'b0; signed_i = 1'b0;
      opa_i = 32'd100; opb_i = 32'd7;
      tick();
      tick();
      @(negedge clk);
      n_chk++;
      if (stall_o !== 1'b0) begin n_fail++; $display("FAIL reset_stall got %b want 0", stall_o); end
      n_chk++;
      if (ready_o !== 1'b0) begin n_fail++; $display("FAIL reset_ready got %b want 0", ready_o); end
      n_chk++;
      if (result_o !== 64'd0) begin n_fail++; $display("FAIL reset_result got %h want 0", result_o); end
      tick();
      rst = 1'b0; start_i = 1'b0;
      @(negedge clk);
      n_chk++;
      if (stall_o !== 1'b0 || ready_o !== 1'b0) begin
         n_fail++; $display("FAIL post_reset_idle got stall=%b ready=%b want 0/0", stall_o, ready_o);
      end
      tick();
   endtask

   task automatic test_table(input string name, input int n, input logic sg [8],
                             input logic [31:0] ta [8], input logic [31:0] tb [8],
                             input logic [63:0] te [8]);
      int sb, ra, pc;
      logic [63:0] res;
      logic sa;
      for (int i = 0; i < n; i++) begin
         do_div(sg[i], ta[i], tb[i], 1'b0, sb, ra, pc, res, sa);
         n_chk++;
         if (res !== te[i]) begin
            n_fail++; $display("FAIL %s[%0d]_result got %h want %h", name, i, res, te[i]);
         end
         n_chk++;
         if (ra !== 33 || pc !== 1) begin
            n_fail++; $display("FAIL %s[%0d]_ready got cycle %0d pulses %0d want 33/1", name, i, ra, pc);
         end
         n_chk++;
         if (sb !== 0) begin
            n_fail++; $display("FAIL %s[%0d]_stall got %0d bad cycles want 0", name, i, sb);
         end
         last_exp = te[i];
      end
   endtask

   task automatic test_divu;
      logic sg [8] = '{8{1'b0}};
      logic [31:0] ta [8] = '{32'd100, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd5,
                              32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 32'd0};
      logic [31:0] tb [8] = '{32'd7, 32'd1, 32'hFFFF_FFFF, 32'd10,
                              32'h8000_0000, 32'hFFFF_FFFF, 32'd1, 32'd1};
      logic [63:0] te [8] = '{64'h00000002_0000000E, 64'h00000000_FFFFFFFF,
                              64'h00000000_00000001, 64'h00000005_00000000,
                              64'h7FFFFFFF_00000001, 64'h80000000_00000000,
                              64'd0, 64'd0};
      test_table("divu", 6, sg, ta, tb, te);
   endtask

   task automatic test_div;
      logic sg [8] = '{8{1'b1}};
      logic [31:0] ta [8] = '{32'hFFFF_FFF9, 32'd7, 32'hFFFF_FFF9, 32'h8000_0000,
                              32'd100, 32'd0, 32'd0, 32'd0};
      logic [31:0] tb [8] = '{32'd2, 32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'hFFFF_FFFF,
                              32'd7, 32'd1, 32'd1, 32'd1};
      logic [63:0] te [8] = '{64'hFFFFFFFF_FFFFFFFD, 64'h00000001_FFFFFFFD,
                              64'hFFFFFFFF_00000003, 64'h00000000_80000000,
                              64'h00000002_0000000E, 64'd0, 64'd0, 64'd0};
      test_table("div", 5, sg, ta, tb, te);
   endtask

   task automatic test_div_zero;
      logic sg [8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      logic [31:0] ta [8] = '{32'h0000_1234, 32'hFFFF_FFF9, 32'h8000_0000,
                              32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
      logic [31:0] tb [8] = '{8{32'd0}};
      logic [63:0] te [8] = '{64'h00001234_FFFFFFFF, 64'hFFFFFFF9_FFFFFFFF,
                              64'h80000000_FFFFFFFF, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0};
      test_table("divzero", 3, sg, ta, tb, te);
   endtask

   task automatic test_cancel_run;
      int pulses, sb, ra, pc;
      logic [63:0] res;
      logic sa;
      pulses = 0;
      signed_i = 1'b0; opa_i = 32'd100; opb_i = 32'd7;
      for (int k = 0; k < 12; k++) begin
         start_i  = (k == 0);
         cancel_i = (k == 10);
         @(negedge clk);
         if (ready_o === 1'b1) pulses++;
         if (k == 10) begin
            n_chk++;
            if (stall_o !== 1'b0) begin n_fail++; $display("FAIL cancel_stall got %b want 0", stall_o); end
         end
         if (k == 11) begin
            n_chk++;
            if (stall_o !== 1'b0) begin n_fail++; $display("FAIL cancel_idle_stall got %b want 0", stall_o); end
            n_chk++;
            if (result_o !== last_exp) begin
               n_fail++; $display("FAIL cancel_hold_result got %h want %h", result_o, last_exp);
            end
         end
         tick();
      end
      cancel_i = 1'b0;
      do_div(1'b0, 32'd1000, 32'd3, 1'b0, sb, ra, pc, res, sa);
      n_chk++;
      if (pulses !== 0) begin n_fail++; $display("FAIL cancel_no_ready got %0d pulses want 0", pulses); end
      n_chk++;
      if (ra + 12 !== 45 || res !== 64'h00000001_0000014D) begin
         n_fail++; $display("FAIL cancel_restart got cycle %0d result %h want 45 %h",
                            ra + 12, res, 64'h00000001_0000014D);
      end
      last_exp = 64'h00000001_0000014D;
   endtask

   task automatic test_cancel_done;
      int pulses;
      pulses = 0;
      signed_i = 1'b0; opa_i = 32'd50; opb_i = 32'd6;
      for (int k = 0; k < 36; k++) begin
         start_i  = (k == 0);
         cancel_i = (k == 33);
         @(negedge clk);
         if (ready_o === 1'b1) pulses++;
         if (k == 34) begin
            n_chk++;
            if (result_o !== 64'h00000002_00000008) begin
               n_fail++; $display("FAIL cancel_done_result got %h want %h", result_o, 64'h00000002_00000008);
            end
            n_chk++;
            if (stall_o !== 1'b0) begin n_fail++; $display("FAIL cancel_done_idle got stall %b want 0", stall_o); end
         end
         tick();
      end
      cancel_i = 1'b0;
      n_chk++;
      if (pulses !== 0) begin n_fail++; $display("FAIL cancel_done_ready got %0d pulses want 0", pulses); end
      last_exp = 64'h00000002_00000008;
   endtask

   task automatic test_rst_mid;
      int pulses, ready_at;
      logic [63:0] res;
      pulses = 0; ready_at = -1; res = 64'd0;
      signed_i = 1'b0; opa_i = 32'd100; opb_i = 32'd7; cancel_i = 1'b0;
      for (int k = 0; k < 44; k++) begin
         start_i = (k < 40);
         rst     = (k == 5);
         if (k >= 1) begin opa_i = 32'd200; opb_i = 32'd9; end
         @(negedge clk);
         if (ready_o === 1'b1) begin
            pulses++;
            if (ready_at < 0) begin ready_at = k; res = result_o; end
         end
         if (k == 5) begin
            n_chk++;
            if (stall_o !== 1'b0 || ready_o !== 1'b0) begin
               n_fail++; $display("FAIL rst_mid_outputs got stall=%b ready=%b want 0/0", stall_o, ready_o);
            end
         end
         if (k == 6) begin
            n_chk++;
            if (result_o !== 64'd0) begin n_fail++; $display("FAIL rst_mid_result got %h want 0", result_o); end
            n_chk++;
            if (stall_o !== 1'b1) begin n_fail++; $display("FAIL rst_reaccept_stall got %b want 1", stall_o); end
         end
         tick();
      end
      rst = 1'b0; start_i = 1'b0;
      n_chk++;
      if (ready_at !== 39 || pulses !== 1) begin
         n_fail++; $display("FAIL rst_reaccept_ready got cycle %0d pulses %0d want 39/1", ready_at, pulses);
      end
      n_chk++;
      if (res !== 64'h00000002_00000016) begin
         n_fail++; $display("FAIL rst_reaccept_result got %h want %h", res, 64'h00000002_00000016);
      end
   endtask

   task automatic test_hold_start;
      int sb, ra, pc;
      logic [63:0] res;
      logic sa;
      do_div(1'b0, 32'd9, 32'd3, 1'b1, sb, ra, pc, res, sa);
      n_chk++;
      if (pc !== 1 || ra !== 33) begin
         n_fail++; $display("FAIL hold_start_ready got %0d pulses at %0d want 1 at 33", pc, ra);
      end
      n_chk++;
      if (sa !== 1'b0) begin n_fail++; $display("FAIL hold_start_idle got stall %b want 0", sa); end
      n_chk++;
      if (res !== 64'h00000000_00000003) begin
         n_fail++; $display("FAIL hold_start_result got %h want %h", res, 64'h00000000_00000003);
      end
   endtask

   initial begin
      rst = 1'b1; start_i = 1'b0; signed_i = 1'b0; cancel_i = 1'b0;
      opa_i = 32'd0; opb_i = 32'd0;
      test_reset();
      test_divu();
      test_div();
      test_div_zero();
      test_cancel_run();
      test_cancel_done();
      test_hold_start();
      test_rst_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
